// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, and the EX/MEM pipeline register with stall/flush.
// One-cycle latency; every output comes straight from the EX/MEM register.
module ex_mem_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       aluCtr,
    input  logic             idValid,
    input  logic [WIDTH-1:0] rsData,
    input  logic [WIDTH-1:0] rtData,
    input  logic [WIDTH-1:0] signImm,
    input  logic             aluSrc,
    input  logic [1:0]       fwdA,
    input  logic [1:0]       fwdB,
    input  logic [WIDTH-1:0] wbData,
    input  logic             regWriteIn,
    input  logic             memReadIn,
    input  logic             memWriteIn,
    input  logic             memToRegIn,
    input  logic [4:0]       writeRegIn,
    input  logic             stall,
    input  logic             flush,
    output logic             exMemValid,
    output logic [WIDTH-1:0] exMemResult,
    output logic [WIDTH-1:0] exMemStoreData,
    output logic             exMemZero,
    output logic [4:0]       exMemWriteReg,
    output logic             exMemRegWrite,
    output logic             exMemMemRead,
    output logic             exMemMemWrite,
    output logic             exMemMemToReg,
    output logic             exMemIllegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] store_data;
        logic             zero;
        logic [4:0]       write_reg;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             illegal;
    } stage_t;

    stage_t stage_q, stage_d, stage_load;

    logic [WIDTH-1:0] fwd_a, fwd_b, op_b, alu_res;
    logic             alu_illegal;

    // Select 10 forwards the currently held EX/MEM result, which stays correct under stall.
    always_comb begin
        case (fwdA)
            2'b01:   fwd_a = wbData;
            2'b10:   fwd_a = stage_q.result;
            default: fwd_a = rsData;
        endcase
        case (fwdB)
            2'b01:   fwd_b = wbData;
            2'b10:   fwd_b = stage_q.result;
            default: fwd_b = rtData;
        endcase
        op_b = aluSrc ? signImm : fwd_b;
    end

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (aluCtr)
            OpAdd:   alu_res = fwd_a + op_b;
            OpSub:   alu_res = fwd_a - op_b;
            OpAnd:   alu_res = fwd_a & op_b;
            OpOr:    alu_res = fwd_a | op_b;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        stage_load            = '0;
        stage_load.valid      = 1'b1;
        stage_load.result     = alu_res;
        stage_load.store_data = fwd_b;
        stage_load.zero       = (alu_res == '0);
        stage_load.write_reg  = writeRegIn;
        // An undefined op must not update architectural state.
        stage_load.reg_write  = regWriteIn & ~alu_illegal;
        stage_load.mem_read   = memReadIn;
        stage_load.mem_write  = memWriteIn & ~alu_illegal;
        stage_load.mem_to_reg = memToRegIn;
        stage_load.illegal    = alu_illegal;
    end

    always_comb begin
        stage_d = stage_q;
        if (flush || (!stall && !idValid)) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d = stage_load;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign exMemValid     = stage_q.valid;
    assign exMemResult    = stage_q.result;
    assign exMemStoreData = stage_q.store_data;
    assign exMemZero      = stage_q.zero;
    assign exMemWriteReg  = stage_q.write_reg;
    assign exMemRegWrite  = stage_q.reg_write;
    assign exMemMemRead   = stage_q.mem_read;
    assign exMemMemWrite  = stage_q.mem_write;
    assign exMemMemToReg  = stage_q.mem_to_reg;
    assign exMemIllegal   = stage_q.illegal;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed corner steps followed by random traffic,
// checked against a behavioural model of the EX/MEM register contents.
module tb_ex_mem_stage;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   aluCtr;
    logic         idValid;
    logic [W-1:0] rsData, rtData, signImm, wbData;
    logic         aluSrc;
    logic [1:0]   fwdA, fwdB;
    logic         regWriteIn, memReadIn, memWriteIn, memToRegIn;
    logic [4:0]   writeRegIn;
    logic         stall, flush;

    logic         exMemValid, exMemZero, exMemRegWrite, exMemMemRead;
    logic         exMemMemWrite, exMemMemToReg, exMemIllegal;
    logic [W-1:0] exMemResult, exMemStoreData;
    logic [4:0]   exMemWriteReg;

    int checks = 0;
    int errors = 0;

    // Model of what the EX/MEM register should hold.
    logic         m_valid, m_zero, m_rw, m_mr, m_mw, m_m2r, m_ill;
    logic [W-1:0] m_result, m_store;
    logic [4:0]   m_wreg;

    ex_mem_stage #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .aluCtr         (aluCtr),
        .idValid        (idValid),
        .rsData         (rsData),
        .rtData         (rtData),
        .signImm        (signImm),
        .aluSrc         (aluSrc),
        .fwdA           (fwdA),
        .fwdB           (fwdB),
        .wbData         (wbData),
        .regWriteIn     (regWriteIn),
        .memReadIn      (memReadIn),
        .memWriteIn     (memWriteIn),
        .memToRegIn     (memToRegIn),
        .writeRegIn     (writeRegIn),
        .stall          (stall),
        .flush          (flush),
        .exMemValid     (exMemValid),
        .exMemResult    (exMemResult),
        .exMemStoreData (exMemStoreData),
        .exMemZero      (exMemZero),
        .exMemWriteReg  (exMemWriteReg),
        .exMemRegWrite  (exMemRegWrite),
        .exMemMemRead   (exMemMemRead),
        .exMemMemWrite  (exMemMemWrite),
        .exMemMemToReg  (exMemMemToReg),
        .exMemIllegal   (exMemIllegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},   W'(exMemValid),    W'(m_valid));
        check({tag, ".result"},  exMemResult,       m_result);
        check({tag, ".store"},   exMemStoreData,    m_store);
        check({tag, ".zero"},    W'(exMemZero),     W'(m_zero));
        check({tag, ".wreg"},    W'(exMemWriteReg), W'(m_wreg));
        check({tag, ".rw"},      W'(exMemRegWrite), W'(m_rw));
        check({tag, ".mr"},      W'(exMemMemRead),  W'(m_mr));
        check({tag, ".mw"},      W'(exMemMemWrite), W'(m_mw));
        check({tag, ".m2r"},     W'(exMemMemToReg), W'(m_m2r));
        check({tag, ".illegal"}, W'(exMemIllegal),  W'(m_ill));
    endtask

    function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] reg_val);
        if (sel == 2'd1) return wbData;
        if (sel == 2'd2) return m_result;
        return reg_val;
    endfunction

    // Compute the model's next register contents from the current inputs, then step the clock.
    task automatic step(input string tag);
        logic [W-1:0] a, fb, b, r;
        logic         bad, lt;
        a  = pick(fwdA, rsData);
        fb = pick(fwdB, rtData);
        b  = aluSrc ? signImm : fb;
        bad = 1'b0;
        r   = '0;
        if (a[W-1] != b[W-1]) lt = a[W-1];
        else                  lt = (a < b);
        if      (aluCtr == 4'd2) r = a + b;
        else if (aluCtr == 4'd6) r = a - b;
        else if (aluCtr == 4'd0) r = a & b;
        else if (aluCtr == 4'd1) r = a | b;
        else if (aluCtr == 4'd7) r = lt ? 1 : 0;
        else                     bad = 1'b1;
        @(posedge clk);
        if (reset || flush || (!stall && !idValid)) begin
            {m_valid, m_zero, m_rw, m_mr, m_mw, m_m2r, m_ill} = '0;
            m_result = '0;
            m_store  = '0;
            m_wreg   = '0;
        end else if (!stall) begin
            m_valid  = 1'b1;
            m_result = r;
            m_store  = fb;
            m_zero   = (r == 0);
            m_wreg   = writeRegIn;
            m_rw     = regWriteIn && !bad;
            m_mr     = memReadIn;
            m_mw     = memWriteIn && !bad;
            m_m2r    = memToRegIn;
            m_ill    = bad;
        end
        #1;
        check_all(tag);
    endtask

    task automatic plain(input logic [3:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
        reset = 0; stall = 0; flush = 0; idValid = 1;
        fwdA = 0; fwdB = 0; aluSrc = 0;
        aluCtr = op; rsData = rs; rtData = rt;
        regWriteIn = 1; memReadIn = 0; memWriteIn = 0; memToRegIn = 0;
        writeRegIn = 5'd3;
    endtask

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0;
            3:       return W'($urandom_range(0, 8));
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs();
        logic [3:0] ops [5] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7};
        aluCtr     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
        idValid    = ($urandom_range(0, 7) != 0);
        rsData     = rand_word();
        rtData     = rand_word();
        signImm    = rand_word();
        wbData     = rand_word();
        aluSrc     = 1'($urandom);
        fwdA       = 2'($urandom);
        fwdB       = 2'($urandom);
        regWriteIn = 1'($urandom);
        memReadIn  = 1'($urandom);
        memWriteIn = 1'($urandom);
        memToRegIn = 1'($urandom);
        writeRegIn = 5'($urandom);
    endtask

    initial begin
        {m_valid, m_zero, m_rw, m_mr, m_mw, m_m2r, m_ill} = '0;
        m_result = '0; m_store = '0; m_wreg = '0;

        // Reset held two cycles with random inputs.
        randomize_inputs();
        stall = 1'($urandom); flush = 1'($urandom);
        reset = 1;
        step("reset1");
        randomize_inputs();
        step("reset2");
        check("reset_valid", W'(exMemValid), 0);

        plain(4'd2, 5, 7);
        step("add_5_7");
        check("add_5_7_const", exMemResult, 12);
        check("add_5_7_valid", W'(exMemValid), 1);

        plain(4'd6, 3, 3);                     step("sub_zero");
        check("sub_zero_flag", W'(exMemZero), 1);
        plain(4'd2, 32'hFFFF_FFFF, 1);         step("add_wrap");
        check("add_wrap_const", exMemResult, 0);
        plain(4'd7, 32'hFFFF_FFFF, 1);         step("slt_neg");
        check("slt_neg_const", exMemResult, 1);
        plain(4'd7, 1, 32'hFFFF_FFFF);         step("slt_pos");
        check("slt_pos_const", exMemResult, 0);
        plain(4'd0, 32'hF0F0, 32'h0FF0);       step("and");
        check("and_const", exMemResult, 32'h00F0);
        plain(4'd1, 32'hF0F0, 32'h0FF0);       step("or");
        check("or_const", exMemResult, 32'hFFF0);

        // Forwarding from EX/MEM and from write-back.
        plain(4'd2, 2, 3);                     step("fwd_base");
        plain(4'd2, 100, 1); fwdA = 2'd2;      step("fwd_exmem");
        check("fwd_exmem_const", exMemResult, 6);
        plain(4'd2, 20, 55); fwdB = 2'd1; wbData = 9; aluSrc = 1; signImm = 4;
        step("fwd_wb");
        check("fwd_wb_result", exMemResult, 24);
        check("fwd_wb_store", exMemStoreData, 9);

        // Stall holds across changing inputs, with select 10 on the held result.
        plain(4'd1, 1, 2);                     step("stall_load");
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            stall = 1; flush = 0; reset = 0;
            step("stall_hold");
            check("stall_hold_const", exMemResult, 3);
        end
        randomize_inputs();
        stall = 1; flush = 1; reset = 0;       step("stall_flush");
        check("stall_flush_valid", W'(exMemValid), 0);

        plain(4'hF, 5, 6); memWriteIn = 1;     step("illegal");
        check("illegal_flag", W'(exMemIllegal), 1);
        check("illegal_rw", W'(exMemRegWrite), 0);

        plain(4'd2, 5, 6); idValid = 0;        step("bubble");
        check("bubble_rw", W'(exMemRegWrite), 0);

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage of the pipelined MIPS datapath, directly downstream of the ALU control decoder. It consumes the 4-bit `aluCtr` code together with ID/EX operands, applies operand forwarding, performs the ALU operation, and captures the result and pass-through control bits in the EX/MEM pipeline register. The register supports stall and flush so the hazard unit can hold or squash the instruction in EX/MEM.

## Interface
- `WIDTH`, 32, datapath width in bits.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `aluCtr` in 4: operation code. 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- `idValid` in 1: ID/EX holds a real instruction.
- `rsData`, `rtData` in WIDTH: register-file operands from ID/EX.
- `signImm` in WIDTH: sign-extended immediate.
- `aluSrc` in 1: 1 selects `signImm` as operand B.
- `fwdA`, `fwdB` in 2: forwarding select. 00 = register, 01 = `wbData`, 10 = `exMemResult`, 11 treated as 00.
- `wbData` in WIDTH: MEM/WB write-back value.
- `regWriteIn`, `memReadIn`, `memWriteIn`, `memToRegIn` in 1 each: control bits from ID/EX.
- `writeRegIn` in 5: destination register.
- `stall` in 1: hold EX/MEM contents.
- `flush` in 1: load a bubble into EX/MEM.
- `exMemValid` out 1; `exMemResult` out WIDTH; `exMemStoreData` out WIDTH; `exMemZero` out 1; `exMemWriteReg` out 5.
- `exMemRegWrite`, `exMemMemRead`, `exMemMemWrite`, `exMemMemToReg` out 1 each.
- `exMemIllegal` out 1: registered flag for an undefined `aluCtr`.

## Operation
- Forwarded A is selected by `fwdA` from `rsData`, `wbData` or `exMemResult`. Forwarded B is selected the same way from `rtData`.
- Operand B equals `aluSrc ? signImm : forwarded B`.
- `exMemStoreData` captures forwarded B, never the immediate.
- add and sub wrap modulo 2^WIDTH, with no overflow trap.
- and and or are bitwise.
- slt compares as signed two's complement. The result is 1 when A < B, else 0, zero-extended.
- Any other `aluCtr`: result 0 and illegal = 1. `regWrite` and `memWrite` are forced to 0 for that instruction; `memRead` and `memToReg` pass through.
- zero = (result == 0), computed on the final result.
- EX/MEM update priority per edge: reset > flush > stall > load.
  - reset or flush: every output register goes to 0, including `exMemValid` and all control bits.
  - stall (no flush): every register holds its value.
  - load with `idValid` = 1: capture the computed values.
  - load with `idValid` = 0: capture a bubble, identical to flush.
- While stalled, forwarding select 10 uses the held `exMemResult`.

## Timing
- Latency: 1 cycle. Inputs presented in cycle N appear on the outputs after the edge ending cycle N.
- Combinational path: forward mux -> ALU -> zero -> register D. There is no combinational path from inputs to outputs.
- Reset value: all outputs 0.
- Reset asserted mid-operation clears the stage on that edge, regardless of stall or flush.
- stall and flush high together: flush wins, a bubble is loaded.
- stall held for K cycles: outputs stay constant for K edges. The input instruction is not consumed; the upstream register must hold it.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> all outputs 0. Release with add, rs=5, rt=7, aluSrc=0, idValid=1 -> next edge gives result 12, zero 0, valid 1.
- Arithmetic corners:
  - sub 3-3 -> result 0, zero 1.
  - add 0xFFFFFFFF+1 -> result 0, zero 1.
  - slt 0xFFFFFFFF vs 1 -> 1.
  - slt 1 vs 0xFFFFFFFF -> 0.
  - and/or 0xF0F0 with 0x0FF0 -> 0x00F0 / 0xFFF0.
- Forwarding:
  - Cycle 1: add 2+3 (result 5).
  - Cycle 2: fwdA=10, rs=100, rt=1 -> result 6.
  - fwdB=01, wbData=9, aluSrc=1, imm=4 -> result A+4, storeData 9.
- Stall/flush:
  - Load or 1|2 (result 3), then stall 3 cycles while inputs change -> outputs hold 3.
  - stall=1 and flush=1 together -> valid 0, all controls 0.
- Illegal op: aluCtr=1111, regWriteIn=1, memWriteIn=1 -> result 0, illegal 1, regWrite 0, memWrite 0, valid 1.
- Bubble: idValid=0 with regWriteIn=1 -> valid 0, regWrite 0, result 0.
